if_id_stage: RTL and testbench
==============================

# if_id_stage

IF/ID pipeline register plus branch/jump resolution and load-use hazard detection for the 5-stage MIPS pipeline. It consumes the fetch stage's `Instruction_if`, `PC` and `IF_flush`, and drives the `Branch`, `Jump`, `JumpAddr` and `IFWrite` signals that steer the fetch stage. It is the ID-side end of the fetch/redirect interface. Control for ID/EX is squashed through `Bubble_id`.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `Instruction_if`  in  32  instruction fetched this cycle
- `PC_if`  in  32  address of `Instruction_if`
- `IF_flush`  in  1  redirect in progress; squash the fetched instruction
- `RsData_id`  in  32  register-file/forwarded value of rs
- `RtData_id`  in  32  register-file/forwarded value of rt
- `MemRead_ex`  in  1  instruction in EX is a load
- `RegisterRt_ex`  in  5  load destination in EX
- `RegWrite_ex`  in  1  EX instruction writes a register (used only with `BRANCH_STALL_EN`)
- `RegisterRd_ex`  in  5  EX write destination (used only with `BRANCH_STALL_EN`)
- `Instruction_id`  out  32  registered instruction
- `PC_id`  out  32  registered PC
- `PCplus4_id`  out  32  `PC_id + 4`, modulo 2^32
- `Valid_id`  out  1  ID slot holds a real instruction
- `Branch`  out  1  taken beq/bne in ID
- `Jump`  out  1  j/jal in ID
- `JumpAddr`  out  32  redirect target
- `IFWrite`  out  1  PC and IF/ID write enable (`= ~Stall`)
- `Bubble_id`  out  1  zero ID/EX control this cycle

## Operation
- Register update priority on each rising edge:
  - `reset` first: `Instruction_id = 0`, `PC_id = 0`, `Valid_id = 0`.
  - Else if `Stall`: hold all three registers.
  - Else if `IF_flush`: `Instruction_id = 0` (nop), `Valid_id = 0`, `PC_id = PC_if`.
  - Else load `Instruction_if`, `PC_if`, and set `Valid_id = 1`.
- Decode is done on `op = Instruction_id[31:26]`: beq `000100`, bne `000101`, j `000010`, jal `000011`. All other opcodes are non-control.
- Load-use hazard: `Stall = Valid_id & MemRead_ex & (RegisterRt_ex != 0) & (RegisterRt_ex == rs | RegisterRt_ex == rt)`, with rs = `[25:21]` and rt = `[20:16]`. Register 0 never stalls.
- `Jump = Valid_id & ~Stall & (j | jal)`.
- `Branch = Valid_id & ~Stall & ((beq & RsData_id == RtData_id) | (bne & RsData_id != RtData_id))`.
- Because `Branch` and `Jump` are gated by `~Stall`, `IFWrite = 0` and `IF_flush = 1` never coincide.
- `JumpAddr`:
  - When `Jump`: `{PCplus4_id[31:28], Instruction_id[25:0], 2'b00}`.
  - Otherwise: `PCplus4_id + (sign-extended imm[15:0] << 2)`, 32-bit with wrap and no overflow flag.
  - Don't-care when neither `Branch` nor `Jump` is asserted.
- `Bubble_id = Stall | ~Valid_id`.
- The jal link write is not handled here.

## Timing
- All outputs other than registers are combinational from the IF/ID registers and the EX-side inputs. There are no added cycles.
- Reset values: `Instruction_id = 0`, `PC_id = 0`, `PCplus4_id = 4`, `Valid_id = 0`, `Branch = 0`, `Jump = 0`, `IFWrite = 1`, `Bubble_id = 1`.
- Redirect, with the control instruction in ID at cycle n:
  - `Branch` or `Jump` is high in cycle n.
  - At the n/n+1 edge, the PC takes `JumpAddr` and the sequential fetch from cycle n becomes a nop with `Valid_id = 0`.
  - Penalty is one bubble.
- Load-use: `Stall` is high for exactly one cycle, since the load leaves EX on the next edge. The consumer remains in ID for that cycle with `Bubble_id = 1`, then proceeds.
- Reset asserted mid-stall or mid-redirect clears the state at that edge. The next cycle shows reset values.

## Configuration
- `BRANCH_STALL_EN` defined:
  - `Stall` additionally asserts when `Valid_id & (beq | bne) & RegWrite_ex & (RegisterRd_ex != 0) & (RegisterRd_ex == rs | RegisterRd_ex == rt)`.
  - This adds a one-cycle stall for branches that depend on an ALU result still in EX.
- `BRANCH_STALL_EN` undefined: that term is removed, and `RegWrite_ex` and `RegisterRd_ex` are ignored.

## Test plan
- Reset, then deassert with `Instruction_if = 0x20080005` at `PC_if = 0x0`. Required:
  - During reset, `Valid_id = 0` and `IFWrite = 1`.
  - One edge later, `Instruction_id = 0x20080005`, `PC_id = 0`, `PCplus4_id = 4`, `Valid_id = 1`.
- beq 0x1109FFFE at `PC_id = 0x10`, with `RsData_id = RtData_id = 7`. Required:
  - `Branch = 1` and `JumpAddr = 0x0C`.
  - With `IF_flush` fed back, the next edge gives `Instruction_id = 0` and `Valid_id = 0`.
  - Repeat with `RtData_id = 8`: `Branch = 0`.
- bne 0x15090003 at `PC_id = 0x20`, with data 1 vs 2. Required: `Branch = 1` and `JumpAddr = 0x30`.
- j 0x08000040 at `PC_id = 0xF0000008`. Required: `Jump = 1` and `JumpAddr = 0xF0000100`.
- `Instruction_id = 0x01095020` (add rd=10, rs=8, rt=9) with `MemRead_ex = 1`, `RegisterRt_ex = 9`. Required:
  - `IFWrite = 0` and `Bubble_id = 1`, and registers hold across the edge.
  - With `RegisterRt_ex = 0`: no stall.
- `BRANCH_STALL_EN` builds only: beq rs=8 with `RegWrite_ex = 1`, `RegisterRd_ex = 8`, data equal. Required:
  - `Stall = 1` and `Branch = 0` for one cycle.
  - The next cycle, with the EX inputs cleared, `Branch = 1`.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with branch/jump resolution and load-use hazard detection.
// Optional feature macro: BRANCH_STALL_EN (stall branches whose operands come from an ALU op still in EX).
module if_id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_if,
    input  logic [31:0] PC_if,
    input  logic        IF_flush,
    input  logic [31:0] RsData_id,
    input  logic [31:0] RtData_id,
    input  logic        MemRead_ex,
    input  logic [4:0]  RegisterRt_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  RegisterRd_ex,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic [31:0] PCplus4_id,
    output logic        Valid_id,
    output logic        Branch,
    output logic        Jump,
    output logic [31:0] JumpAddr,
    output logic        IFWrite,
    output logic        Bubble_id
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic        is_beq, is_bne, is_jump;
    logic        load_use, branch_dep, stall;
    logic [31:0] pc_plus4, branch_off;

    always_comb begin
        op       = instr_q[31:26];
        rs       = instr_q[25:21];
        rt       = instr_q[20:16];
        is_beq   = (op == OP_BEQ);
        is_bne   = (op == OP_BNE);
        is_jump  = (op == OP_J) || (op == OP_JAL);
        pc_plus4 = pc_q + 32'd4;
        // Branch offset is a word offset: sign-extend and shift left by two.
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end

    // Register 0 is hardwired to zero, so it never creates a dependency.
    assign load_use = valid_q && MemRead_ex && (RegisterRt_ex != 5'd0) &&
                      ((RegisterRt_ex == rs) || (RegisterRt_ex == rt));

`ifdef BRANCH_STALL_EN
    assign branch_dep = valid_q && (is_beq || is_bne) && RegWrite_ex &&
                        (RegisterRd_ex != 5'd0) &&
                        ((RegisterRd_ex == rs) || (RegisterRd_ex == rt));
`else
    logic unused_ex;
    assign unused_ex  = ^{RegWrite_ex, RegisterRd_ex};
    assign branch_dep = 1'b0;
`endif

    assign stall = load_use || branch_dep;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (!stall) begin
            if (IF_flush) begin
                instr_d = 32'd0;
                pc_d    = PC_if;
                valid_d = 1'b0;
            end else begin
                instr_d = Instruction_if;
                pc_d    = PC_if;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Redirects are suppressed while stalled so a flush never meets a held IF/ID.
    always_comb begin
        Jump   = valid_q && !stall && is_jump;
        Branch = valid_q && !stall &&
                 ((is_beq && (RsData_id == RtData_id)) ||
                  (is_bne && (RsData_id != RtData_id)));
        if (Jump) begin
            JumpAddr = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else begin
            JumpAddr = pc_plus4 + branch_off;
        end
    end

    assign Instruction_id = instr_q;
    assign PC_id          = pc_q;
    assign PCplus4_id     = pc_plus4;
    assign Valid_id       = valid_q;
    assign IFWrite        = !stall;
    assign Bubble_id      = stall || !valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: driver pushes expected ID-stage state per cycle,
// monitor pops and compares on the falling edge.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instruction_if;
  logic [31:0] pc_if;
  logic        if_flush;
  logic [31:0] rs_data_id;
  logic [31:0] rt_data_id;
  logic        mem_read_ex;
  logic [4:0]  register_rt_ex;
  logic        reg_write_ex;
  logic [4:0]  register_rd_ex;
  logic [31:0] instruction_id;
  logic [31:0] pc_id;
  logic [31:0] pcplus4_id;
  logic        valid_id;
  logic        branch;
  logic        jump;
  logic [31:0] jump_addr;
  logic        if_write;
  logic        bubble_id;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        valid;
    logic        br;
    logic        jp;
    logic [31:0] ja;
    logic        chk_ja;
    logic        ifw;
    logic        bub;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  bit    drive_done = 0;

  if_id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .Instruction_if (instruction_if),
    .PC_if          (pc_if),
    .IF_flush       (if_flush),
    .RsData_id      (rs_data_id),
    .RtData_id      (rt_data_id),
    .MemRead_ex     (mem_read_ex),
    .RegisterRt_ex  (register_rt_ex),
    .RegWrite_ex    (reg_write_ex),
    .RegisterRd_ex  (register_rd_ex),
    .Instruction_id (instruction_id),
    .PC_id          (pc_id),
    .PCplus4_id     (pcplus4_id),
    .Valid_id       (valid_id),
    .Branch         (branch),
    .Jump           (jump),
    .JumpAddr       (jump_addr),
    .IFWrite        (if_write),
    .Bubble_id      (bubble_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc, input logic flush);
    instruction_if = ins;
    pc_if          = pc;
    if_flush       = flush;
  endtask

  task automatic ex_side(input logic mr, input logic [4:0] rt_ex, input logic rw, input logic [4:0] rd_ex);
    mem_read_ex    = mr;
    register_rt_ex = rt_ex;
    reg_write_ex   = rw;
    register_rd_ex = rd_ex;
  endtask

  task automatic expect_id(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                           input logic v, input logic br, input logic jp,
                           input logic [31:0] ja, input logic chk_ja,
                           input logic ifw, input logic bub);
    exp_t e;
    e.ins    = ins;
    e.pc     = pc;
    e.pcp4   = pc + 32'd4;
    e.valid  = v;
    e.br     = br;
    e.jp     = jp;
    e.ja     = ja;
    e.chk_ja = chk_ja;
    e.ifw    = ifw;
    e.bub    = bub;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, field, act, exp);
    end
  endtask

  // monitor
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "Instruction_id", instruction_id, e.ins);
        chk(nm, "PC_id",          pc_id,          e.pc);
        chk(nm, "PCplus4_id",     pcplus4_id,     e.pcp4);
        chk(nm, "Valid_id",       {31'd0, valid_id},  {31'd0, e.valid});
        chk(nm, "Branch",         {31'd0, branch},    {31'd0, e.br});
        chk(nm, "Jump",           {31'd0, jump},      {31'd0, e.jp});
        chk(nm, "IFWrite",        {31'd0, if_write},  {31'd0, e.ifw});
        chk(nm, "Bubble_id",      {31'd0, bubble_id}, {31'd0, e.bub});
        if (e.chk_ja) chk(nm, "JumpAddr", jump_addr, e.ja);
      end
    end
  end

  // stimulus
  initial begin
    reset      = 1'b1;
    rs_data_id = 32'd0;
    rt_data_id = 32'd0;
    fetch(32'h2008_0005, 32'h0, 1'b0);
    ex_side(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
    expect_id("reset", 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 1);

    tick();
    reset = 1'b0;
    expect_id("reset_last_edge", 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 1);

    tick();
    fetch(32'h1109_FFFE, 32'h10, 1'b0);
    rs_data_id = 32'd7;
    rt_data_id = 32'd7;
    expect_id("first_load", 32'h2008_0005, 32'h0, 1, 0, 0, 32'h0, 0, 1, 0);

    tick();
    fetch(32'hDEAD_BEEF, 32'h14, 1'b1);
    expect_id("beq_taken", 32'h1109_FFFE, 32'h10, 1, 1, 0, 32'h0000_000C, 1, 1, 0);

    tick();
    fetch(32'h1109_FFFE, 32'h10, 1'b0);
    expect_id("beq_flushed", 32'h0, 32'h14, 0, 0, 0, 32'h0, 0, 1, 1);

    tick();
    rt_data_id = 32'd8;
    fetch(32'h1509_0003, 32'h20, 1'b0);
    expect_id("beq_not_taken", 32'h1109_FFFE, 32'h10, 1, 0, 0, 32'h0, 0, 1, 0);

    tick();
    rs_data_id = 32'd1;
    rt_data_id = 32'd2;
    fetch(32'h0800_0040, 32'hF000_0008, 1'b0);
    expect_id("bne_taken", 32'h1509_0003, 32'h20, 1, 1, 0, 32'h0000_0030, 1, 1, 0);

    tick();
    fetch(32'h0109_5020, 32'h40, 1'b0);
    expect_id("j_taken", 32'h0800_0040, 32'hF000_0008, 1, 0, 1, 32'hF000_0100, 1, 1, 0);

    tick();
    fetch(32'h012A_5820, 32'h44, 1'b0);
    ex_side(1'b1, 5'd9, 1'b0, 5'd0);
    expect_id("load_use_rt", 32'h0109_5020, 32'h40, 1, 0, 0, 32'h0, 0, 0, 1);

    tick();
    ex_side(1'b1, 5'd0, 1'b0, 5'd0);
    expect_id("load_use_held_rt0", 32'h0109_5020, 32'h40, 1, 0, 0, 32'h0, 0, 1, 0);

    tick();
    ex_side(1'b1, 5'd9, 1'b0, 5'd0);
    reset = 1'b1;
    expect_id("load_use_rs", 32'h012A_5820, 32'h44, 1, 0, 0, 32'h0, 0, 0, 1);

    tick();
    reset = 1'b0;
    ex_side(1'b0, 5'd0, 1'b0, 5'd0);
    fetch(32'h1109_FFFE, 32'h10, 1'b0);
    expect_id("reset_mid_stall", 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 1);

`ifdef BRANCH_STALL_EN
    tick();
    rs_data_id = 32'd7;
    rt_data_id = 32'd7;
    ex_side(1'b0, 5'd0, 1'b1, 5'd8);
    fetch(32'h0000_0000, 32'h14, 1'b0);
    expect_id("branch_dep_stall", 32'h1109_FFFE, 32'h10, 1, 0, 0, 32'h0, 0, 0, 1);

    tick();
    ex_side(1'b0, 5'd0, 1'b0, 5'd0);
    expect_id("branch_dep_release", 32'h1109_FFFE, 32'h10, 1, 1, 0, 32'h0000_000C, 1, 1, 0);
`else
    tick();
    rs_data_id = 32'd7;
    rt_data_id = 32'd7;
    ex_side(1'b0, 5'd0, 1'b1, 5'd8);
    fetch(32'h0000_0000, 32'h14, 1'b0);
    expect_id("branch_dep_ignored", 32'h1109_FFFE, 32'h10, 1, 1, 0, 32'h0000_000C, 1, 1, 0);
`endif

    drive_done = 1'b1;
  end

  // final report
  initial begin
    int budget;
    budget = 0;
    while (!(drive_done && exp_q.size() == 0) && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
